pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage ARM pipeline by driving PC enable, IF/ID enable/flush and the cu_mux NOP select.
//  Detects load-use hazards and inserts bubbles; flushes IF/ID on a taken branch resolved in ID.
//  Produces forwarding selects for both ALU operands and keeps saturating stall/flush performance counters.
//  Sits beside the control unit, between the ID stage and the ID/EX, EX/MEM and MEM/WB pipeline registers.
// PARAMETERS
//  STALL_CYCLES  1   bubbles inserted per load-use hazard (>=1)
//  CNT_W         16  width of stall_count / flush_count
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-high
//  id_rn         in   4      ID source register A
//  id_rn_used    in   1      ID instruction reads id_rn
//  id_rm         in   4      ID source register B
//  id_rm_used    in   1      ID instruction reads id_rm
//  id_branch     in   1      taken branch in ID (PCSrc, already condition-qualified)
//  ex_rd         in   4      ID/EX destination register
//  ex_reg_write  in   1      ID/EX RegWrite
//  ex_load       in   1      ID/EX MemtoReg (load in EX)
//  mem_rd        in   4      EX/MEM destination register
//  mem_reg_write in   1      EX/MEM RegWrite
//  wb_rd         in   4      MEM/WB destination register
//  wb_reg_write  in   1      MEM/WB RegWrite
//  pc_enable     out  1      program counter enable
//  if_id_enable  out  1      IF/ID enable
//  if_id_flush   out  1      IF/ID loads NOP at next edge
//  cu_mux_nop    out  1      cu_mux forces all control outputs to 0
//  fwd_a, fwd_b  out  2      operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
//  stall_count   out  CNT_W  bubble cycles inserted (saturating)
//  flush_count   out  CNT_W  flush events (saturating)
// BEHAVIOUR
//  Reset (async, immediate): state=RUN, counters=0, pending count=0. While reset is high: pc_enable=0,
//   if_id_enable=0, cu_mux_nop=1, if_id_flush=0, fwd_a/b=00.
//  Hazard decode is combinational, so outputs respond in the same cycle. State, counters and pending count update on the clk rising edge.
//  hz = ex_load & ex_reg_write & ex_rd!=15 & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd)).
//  FSM RUN:
//   - If hz: stall this cycle (pc_enable=0, if_id_enable=0, cu_mux_nop=1).
//   - If hz and STALL_CYCLES>1: go to STALL with rem=STALL_CYCLES-1.
//   - Else if id_branch: if_id_flush=1 for 1 cycle, flush_count++, stay in RUN.
//   - Else: all enables=1, nop=0, flush=0.
//  FSM STALL: stall outputs held; rem--. At rem==1, return to RUN on the next edge. Inputs in STALL are ignored for hazard detection.
//  Priority: stall beats branch. id_branch coincident with hz is ignored that cycle; it is re-evaluated when the instruction
//   leaves stall, because the branch may depend on the load.
//  Flush never deasserts pc_enable: the branch target is loaded by the PC path.
//  Forwarding per operand, gated by *_used:
//   - Priority EX(01, ex_reg_write & !ex_load) > MEM(10) > WB(11) > 00.
//   - Match requires the rd equality plus the corresponding reg_write.
//   - R15 is never forwarded; an unused operand gives 00.
//  stall_count increments every stall cycle; flush_count increments every flush cycle. Both hold at 2^CNT_W-1 (no wrap).
//  Reset mid-STALL aborts the stall; the first post-reset cycle is RUN.
// STRUCTURE
//  Package arm_pipe_pkg:
//   - FWD_REG/FWD_EX/FWD_MEM/FWD_WB encodings
//   - state enum {RUN, STALL}
//   - REG_PC = 4'd15
//  Sub-module fwd_select (combinational, one per operand):
//   - inputs: src, used, ex/mem/wb rd + write/load
//   - output: 2-bit select
//  Top holds the FSM, rem counter (clog2(STALL_CYCLES+1) bits) and perf counters.
// TESTING
//  1. Reset held 3 cycles with any inputs -> pc_enable=0, if_id_enable=0, cu_mux_nop=1, counters=0.
//     After release, no hazard -> enables=1, nop=0.
//  2. ex_load=1, ex_reg_write=1, ex_rd=2, id_rm=2, id_rm_used=1 -> 1 bubble (nop=1, enables=0), stall_count=1.
//     Next cycle with mem_rd=2, mem_reg_write=1 -> fwd_b=10.
//  3. id_branch=1, no hazard -> if_id_flush=1 for exactly 1 cycle, pc_enable=1, flush_count=1.
//     Same with hz=1 -> no flush, stall taken.
//  4. ex_rd=mem_rd=wb_rd=5, all writes=1, ex_load=0, id_rn=5 used -> fwd_a=01.
//     Drop ex_reg_write -> 10. Drop mem_reg_write -> 11.
//     id_rn=15 -> 00 regardless of matches.
//  5. STALL_CYCLES=3 with a hazard -> 3 consecutive bubble cycles, then RUN.
//     Reset asserted in 2nd bubble -> immediate RUN, counters=0.
//  6. CNT_W=4, force 20 stalls -> stall_count saturates at 15.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared encodings and helpers for the ARM pipeline hazard/forwarding logic.
package arm_pipe_pkg;

    // Operand source select driven into the EX-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Pipeline sequencing states.
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    // R15 is the PC; its value comes from the PC path, never from a producer stage.
    localparam logic [3:0] REG_PC = 4'd15;

    // True when a consumer operand reads a register that a producer is writing.
    function automatic logic reg_match(input logic [3:0] src,
                                       input logic       used,
                                       input logic [3:0] rd,
                                       input logic       wr);
        return used && wr && (src == rd) && (src != REG_PC);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: picks the youngest producer holding the operand.
module fwd_select
    import arm_pipe_pkg::*;
(
    input  logic [3:0] src,
    input  logic       used,
    input  logic [3:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_load,
    input  logic [3:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [3:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);

    // Youngest producer wins; a load in EX has no data yet, so it cannot forward.
    always_comb begin
        // NOTE: default assignment first so every path drives sel and no latch is inferred.
        sel = FWD_REG;
        if (reg_match(src, used, ex_rd, ex_reg_write && !ex_load))
            sel = FWD_EX;
        else if (reg_match(src, used, mem_rd, mem_reg_write))
            sel = FWD_MEM;
        else if (reg_match(src, used, wb_rd, wb_reg_write))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and operand forwarding control for the 5-stage ARM pipeline.
module pipeline_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic             id_rn_used,
    input  logic [3:0]       id_rm,
    input  logic             id_rm_used,
    input  logic             id_branch,
    input  logic [3:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_load,
    input  logic [3:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [3:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             cu_mux_nop,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                REM_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [REM_W-1:0]  REM_LOAD = REM_W'(STALL_CYCLES - 1);
    localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);

    state_e           state;
    logic [REM_W-1:0] rem;
    logic             hz;
    logic             stall_now;
    logic             flush_now;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    // Load-use hazard: the ID instruction reads the register a load in EX is still fetching.
    always_comb begin
        hz = reg_match(id_rn, id_rn_used, ex_rd, ex_load && ex_reg_write)
          || reg_match(id_rm, id_rm_used, ex_rd, ex_load && ex_reg_write);
    end

    // Stall beats branch; in STALL the ID inputs are not examined at all, so a branch
    // that depends on the load is only acted on once it leaves the stall.
    always_comb begin
        stall_now = (state == STALL) || hz;
        flush_now = (state == RUN) && !hz && id_branch;
    end

    // Outputs are decoded combinationally so a hazard is held off in the cycle it appears;
    // reset overrides them so nothing advances while the pipeline is being cleared.
    always_comb begin
        pc_enable    = !reset && !stall_now;
        if_id_enable = !reset && !stall_now;
        cu_mux_nop   = reset || stall_now;
        if_id_flush  = !reset && flush_now;
        fwd_a        = reset ? FWD_REG : fwd_a_raw;
        fwd_b        = reset ? FWD_REG : fwd_b_raw;
    end

    fwd_select u_fwd_a (
        .src           (id_rn),
        .used          (id_rn_used),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_load       (ex_load),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .src           (id_rm),
        .used          (id_rm_used),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_load       (ex_load),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_raw)
    );

    // Sequencer: the first bubble is taken in RUN, the remaining STALL_CYCLES-1 in STALL.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz && (STALL_CYCLES > 1)) begin
                        state <= STALL;
                        rem   <= REM_LOAD;
                    end
                end
                STALL: begin
                    rem <= rem - REM_ONE;
                    if (rem == REM_ONE)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating performance counters: one count per bubble cycle and per flush cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_now && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_now && !(&flush_count))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
